scaler_v_ctrl: RTL and testbench

//  Frame-synchronous sequencer for scaler_v. Measures active input line width,

---
 rtl/scaler_v_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_scaler_v_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/scaler_v_ctrl.sv
// scaler_v_ctrl: frame-synchronous sequencer deriving scaler_v step/line size in vblank.
// Optional statistics outputs are enabled by defining SCALER_V_CTRL_STAT_EN.
module scaler_v_ctrl #(
  parameter int LINE_STEP     = 4096,
  parameter int STEP_MIN      = 256,
  parameter int LINE_SIZE_MAX = 4096,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 de_i,
  input  logic                 hs_i,
  input  logic                 vs_i,
  input  logic [15:0]          cfg_step_i,
  input  logic                 cfg_wr_i,
  input  logic                 err_clr_i,
  output logic [15:0]          scale_step_o,
  output logic [CNT_WIDTH-1:0] scale_line_size_o,
  output logic                 upd_o,
  output logic [CNT_WIDTH-1:0] width_o,
  output logic                 pend_o,
  output logic                 busy_o,
  output logic                 err_o
`ifdef SCALER_V_CTRL_STAT_EN
  ,
  output logic [CNT_WIDTH-1:0] stat_height_o,
  output logic [15:0]          stat_frames_o
`endif
);

  localparam int ACC_W = CNT_WIDTH + 13;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_APPLY} state_t;

  state_t               state_q, state_d;
  logic                 vs_q, vs_d, rise_q, rise_d;
  logic [CNT_WIDTH-1:0] pix_cnt_q, pix_cnt_d, width_q, width_d;
  logic [CNT_WIDTH-1:0] applied_w_q, applied_w_d, size_q, size_d;
  logic [15:0]          shadow_q, shadow_d, step_q, step_d;
  logic                 pend_q, pend_d, err_q, err_d, upd_q, upd_d;
  logic                 wr_seen_q, wr_seen_d;
  logic [15:0]          st_q, st_d;
  logic [ACC_W-1:0]     tgt_q, tgt_d, acc_q, acc_d, nxt;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 wr_ok, wr_bad, close, trigger, fits, abort;

  always_comb begin
    wr_ok   = cfg_wr_i && (cfg_step_i >= 16'(STEP_MIN));
    wr_bad  = cfg_wr_i && !wr_ok;
    close   = (hs_i || vs_i) && (pix_cnt_q != '0);
    rise_d  = vs_i && !vs_q;
    vs_d    = vs_i;
    // The trigger acts one clock after the rise is sampled (registered edge detect).
    trigger = rise_q && (state_q == S_IDLE) && (pend_q || (width_q != applied_w_q))
              && (width_q != '0);
    nxt     = acc_q + ACC_W'(st_q);
    fits    = (nxt <= tgt_q);
    abort   = (state_q == S_CALC) &&
              (!vs_i || (fits && (cnt_q >= CNT_WIDTH'(LINE_SIZE_MAX))));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (trigger) state_d = S_CALC;
      S_CALC:  if (abort) state_d = S_IDLE;
               else if (!fits) state_d = S_APPLY;
      S_APPLY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    pix_cnt_d   = pix_cnt_q;
    width_d     = width_q;
    shadow_d    = shadow_q;
    pend_d      = pend_q;
    err_d       = err_q;
    upd_d       = 1'b0;
    step_d      = step_q;
    size_d      = size_q;
    applied_w_d = applied_w_q;
    wr_seen_d   = wr_seen_q;
    st_d        = st_q;
    tgt_d       = tgt_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;

    if (hs_i || vs_i) begin
      if (close) begin
        width_d   = pix_cnt_q;
        pix_cnt_d = '0;
      end
    end else if (de_i && (pix_cnt_q != '1)) begin
      pix_cnt_d = pix_cnt_q + CNT_WIDTH'(1);
    end

    if (wr_ok) begin
      shadow_d = cfg_step_i;
      pend_d   = 1'b1;
    end

    // A write coinciding with the trigger misses the snapshot, so it counts as pending.
    if (trigger)    wr_seen_d = wr_ok;
    else if (wr_ok) wr_seen_d = 1'b1;

    if (trigger) begin
      st_d  = shadow_q;
      tgt_d = ACC_W'(width_q - CNT_WIDTH'(1)) * ACC_W'(LINE_STEP);
      acc_d = '0;
      cnt_d = CNT_WIDTH'(1);
    end else if ((state_q == S_CALC) && fits && !abort) begin
      acc_d = nxt;
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    if (state_q == S_APPLY) begin
      step_d      = st_q;
      size_d      = cnt_q;
      upd_d       = 1'b1;
      pend_d      = wr_seen_q || wr_ok;
      applied_w_d = width_q;
    end

    if (err_clr_i)        err_d = 1'b0;
    if (wr_bad || abort)  err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q        <= 1'b0;
      rise_q      <= 1'b0;
      pix_cnt_q   <= '0;
      width_q     <= '0;
      shadow_q    <= 16'(LINE_STEP);
      pend_q      <= 1'b0;
      err_q       <= 1'b0;
      upd_q       <= 1'b0;
      step_q      <= 16'(LINE_STEP);
      size_q      <= '0;
      applied_w_q <= '0;
      wr_seen_q   <= 1'b0;
    end else begin
      vs_q        <= vs_d;
      rise_q      <= rise_d;
      pix_cnt_q   <= pix_cnt_d;
      width_q     <= width_d;
      shadow_q    <= shadow_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
      upd_q       <= upd_d;
      step_q      <= step_d;
      size_q      <= size_d;
      applied_w_q <= applied_w_d;
      wr_seen_q   <= wr_seen_d;
    end
  end

  // Calculation datapath: only meaningful after a trigger snapshot.
  always_ff @(posedge clk) begin
    st_q  <= st_d;
    tgt_q <= tgt_d;
    acc_q <= acc_d;
    cnt_q <= cnt_d;
  end

  assign scale_step_o      = step_q;
  assign scale_line_size_o = size_q;
  assign upd_o             = upd_q;
  assign width_o           = width_q;
  assign pend_o            = pend_q;
  assign busy_o            = (state_q != S_IDLE);
  assign err_o             = err_q;

`ifdef SCALER_V_CTRL_STAT_EN
  logic [CNT_WIDTH-1:0] line_cnt_q, line_cnt_d, height_q, height_d;
  logic [15:0]          frames_q, frames_d;

  always_comb begin
    line_cnt_d = line_cnt_q;
    height_d   = height_q;
    frames_d   = frames_q;
    if (rise_d) begin
      height_d   = line_cnt_q + (close ? CNT_WIDTH'(1) : CNT_WIDTH'(0));
      line_cnt_d = '0;
      frames_d   = frames_q + 16'd1;
    end else if (close) begin
      line_cnt_d = line_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_cnt_q <= '0;
      height_q   <= '0;
      frames_q   <= '0;
    end else begin
      line_cnt_q <= line_cnt_d;
      height_q   <= height_d;
      frames_q   <= frames_d;
    end
  end

  assign stat_height_o = height_q;
  assign stat_frames_o = frames_q;
`endif

endmodule

// File: tb/tb_scaler_v_ctrl.sv
// Directed bench for scaler_v_ctrl: frame timing, step writes, aborts, reset.
// Define SCALER_V_CTRL_STAT_EN to also exercise the statistics outputs.
module tb_scaler_v_ctrl;

  logic        clk = 1'b0;
  logic        rst, de_i, hs_i, vs_i, cfg_wr_i, err_clr_i;
  logic [15:0] cfg_step_i;
  logic [15:0] scale_step_o;
  logic [15:0] scale_line_size_o, width_o;
  logic        upd_o, pend_o, busy_o, err_o;
`ifdef SCALER_V_CTRL_STAT_EN
  logic [15:0] stat_height_o, stat_frames_o;
`endif

  int checks = 0;
  int errors = 0;
  int upd_cnt, upd_at;

  scaler_v_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .de_i              (de_i),
    .hs_i              (hs_i),
    .vs_i              (vs_i),
    .cfg_step_i        (cfg_step_i),
    .cfg_wr_i          (cfg_wr_i),
    .err_clr_i         (err_clr_i),
    .scale_step_o      (scale_step_o),
    .scale_line_size_o (scale_line_size_o),
    .upd_o             (upd_o),
    .width_o           (width_o),
    .pend_o            (pend_o),
    .busy_o            (busy_o),
    .err_o             (err_o)
`ifdef SCALER_V_CTRL_STAT_EN
    ,
    .stat_height_o     (stat_height_o),
    .stat_frames_o     (stat_frames_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic line(input int w);
    de_i = 1'b1;
    for (int i = 0; i < w; i++) tick();
    de_i = 1'b0;
    hs_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    hs_i = 1'b0;
  endtask

  task automatic frame(input int w, input int h);
    for (int i = 0; i < h; i++) line(w);
  endtask

  task automatic wr(input logic [15:0] v);
    cfg_wr_i   = 1'b1;
    cfg_step_i = v;
    tick();
    cfg_wr_i = 1'b0;
  endtask

  task automatic clr();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
  endtask

  // upd_at = clocks after the edge that first samples vs_i high; -1 if none.
  task automatic vblank(input int n, input int wr_at, input logic [15:0] wr_val);
    upd_cnt = 0;
    upd_at  = -1;
    vs_i    = 1'b1;
    tick();
    for (int i = 1; i <= n; i++) begin
      if (i == n) vs_i = 1'b0;
      tick();
      cfg_wr_i = 1'b0;
      if (upd_o === 1'b1) begin
        upd_cnt++;
        if (upd_at < 0) upd_at = i;
      end
      if (i == wr_at) begin
        cfg_wr_i   = 1'b1;
        cfg_step_i = wr_val;
      end
    end
    cfg_wr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
    cfg_wr_i = 1'b0; err_clr_i = 1'b0; cfg_step_i = 16'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++; if (scale_step_o !== 16'd4096) begin errors++; $display("FAIL rst_step got %0d want 4096", scale_step_o); end
    checks++; if (scale_line_size_o !== 16'd0) begin errors++; $display("FAIL rst_size got %0d want 0", scale_line_size_o); end
    checks++; if (width_o !== 16'd0) begin errors++; $display("FAIL rst_width got %0d want 0", width_o); end
    checks++; if ({upd_o, pend_o, busy_o, err_o} !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b want 0000", {upd_o, pend_o, busy_o, err_o}); end
  endtask

  task automatic test_first_frame();
    frame(24, 3);
    checks++; if (width_o !== 16'd24) begin errors++; $display("FAIL width24 got %0d want 24", width_o); end
    vblank(60, -1, 16'd0);
    checks++; if (upd_cnt !== 1) begin errors++; $display("FAIL first_upd_cnt got %0d want 1", upd_cnt); end
    checks++; if (upd_at !== 26) begin errors++; $display("FAIL first_upd_at got %0d want 26", upd_at); end
    checks++; if (scale_step_o !== 16'd4096 || scale_line_size_o !== 16'd24) begin errors++; $display("FAIL first_out got %0d/%0d want 4096/24", scale_step_o, scale_line_size_o); end
    frame(24, 3);
    vblank(60, -1, 16'd0);
    checks++; if (upd_cnt !== 0) begin errors++; $display("FAIL second_upd_cnt got %0d want 0", upd_cnt); end
  endtask

  task automatic test_write_2048();
    frame(24, 1);
    wr(16'd2048);
    checks++; if (pend_o !== 1'b1) begin errors++; $display("FAIL pend_after_wr got %b want 1", pend_o); end
    frame(24, 2);
    vblank(60, -1, 16'd0);
    checks++; if (upd_at !== 49) begin errors++; $display("FAIL upd_at_2048 got %0d want 49", upd_at); end
    checks++; if (scale_step_o !== 16'd2048 || scale_line_size_o !== 16'd47) begin errors++; $display("FAIL out_2048 got %0d/%0d want 2048/47", scale_step_o, scale_line_size_o); end
    checks++; if (pend_o !== 1'b0) begin errors++; $display("FAIL pend_cleared got %b want 0", pend_o); end
  endtask

  task automatic test_reject();
    wr(16'd8192);
    frame(24, 2);
    vblank(40, -1, 16'd0);
    checks++; if (scale_step_o !== 16'd8192 || scale_line_size_o !== 16'd12 || upd_at !== 14) begin errors++; $display("FAIL out_8192 got %0d/%0d@%0d want 8192/12@14", scale_step_o, scale_line_size_o, upd_at); end
    wr(16'd100);
    checks++; if (err_o !== 1'b1 || pend_o !== 1'b0) begin errors++; $display("FAIL bad_wr err/pend got %b%b want 10", err_o, pend_o); end
    frame(24, 1);
    vblank(30, -1, 16'd0);
    checks++; if (upd_cnt !== 0 || scale_step_o !== 16'd8192) begin errors++; $display("FAIL shadow_kept got upd %0d step %0d want 0/8192", upd_cnt, scale_step_o); end
    // Clear together with a rejected write (255 is just below the minimum): set wins.
    err_clr_i = 1'b1;
    wr(16'd255);
    err_clr_i = 1'b0;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL set_wins got %b want 1", err_o); end
    clr();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_clr got %b want 0", err_o); end
  endtask

  task automatic test_abort();
    wr(16'd256);
    frame(600, 2);
    vblank(1000, -1, 16'd0);
    checks++; if (upd_cnt !== 0 || err_o !== 1'b1 || pend_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL vs_abort got upd %0d err %b pend %b busy %b want 0/1/1/0", upd_cnt, err_o, pend_o, busy_o); end
    checks++; if (scale_step_o !== 16'd8192 || scale_line_size_o !== 16'd12) begin errors++; $display("FAIL vs_abort_out got %0d/%0d want 8192/12", scale_step_o, scale_line_size_o); end
    clr();
    frame(600, 2);
    vblank(4300, -1, 16'd0);
    checks++; if (upd_cnt !== 0 || err_o !== 1'b1 || scale_line_size_o !== 16'd12) begin errors++; $display("FAIL max_abort got upd %0d err %b size %0d want 0/1/12", upd_cnt, err_o, scale_line_size_o); end
    clr();
    frame(256, 2);
    vblank(4200, -1, 16'd0);
    checks++; if (scale_line_size_o !== 16'd4081 || scale_step_o !== 16'd256 || upd_at !== 4083) begin errors++; $display("FAIL out_256 got %0d/%0d@%0d want 4081/256@4083", scale_line_size_o, scale_step_o, upd_at); end
    checks++; if (pend_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL out_256_flags got %b%b want 00", pend_o, err_o); end
    frame(257, 2);
    vblank(4200, -1, 16'd0);
    checks++; if (upd_cnt !== 0 || err_o !== 1'b1 || scale_line_size_o !== 16'd4081) begin errors++; $display("FAIL max_plus1 got upd %0d err %b size %0d want 0/1/4081", upd_cnt, err_o, scale_line_size_o); end
    clr();
  endtask

  task automatic test_width_change();
    wr(16'd4096);
    frame(24, 2);
    vblank(60, -1, 16'd0);
    checks++; if (scale_line_size_o !== 16'd24 || upd_at !== 26) begin errors++; $display("FAIL back_4096 got %0d@%0d want 24@26", scale_line_size_o, upd_at); end
    frame(13, 2);
    vblank(40, -1, 16'd0);
    checks++; if (upd_cnt !== 1 || scale_line_size_o !== 16'd13 || upd_at !== 15) begin errors++; $display("FAIL width13 got %0d x%0d @%0d want 13 x1 @15", scale_line_size_o, upd_cnt, upd_at); end
    wr(16'd8192);
    frame(13, 1);
    vblank(40, 3, 16'd2048);
    checks++; if (scale_step_o !== 16'd8192 || scale_line_size_o !== 16'd7 || pend_o !== 1'b1) begin errors++; $display("FAIL wr_in_calc got %0d/%0d pend %b want 8192/7 pend 1", scale_step_o, scale_line_size_o, pend_o); end
    frame(13, 1);
    vblank(40, -1, 16'd0);
    checks++; if (scale_step_o !== 16'd2048 || scale_line_size_o !== 16'd25 || upd_at !== 27 || pend_o !== 1'b0) begin errors++; $display("FAIL retry got %0d/%0d@%0d pend %b want 2048/25@27 pend 0", scale_step_o, scale_line_size_o, upd_at, pend_o); end
  endtask

  task automatic test_rst_mid_calc();
    wr(16'd8192);
    frame(13, 1);
    vs_i = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL busy_calc got %b want 1", busy_o); end
    rst = 1'b1;
    tick();
    checks++; if (scale_step_o !== 16'd4096 || scale_line_size_o !== 16'd0 || width_o !== 16'd0) begin errors++; $display("FAIL rst_mid got %0d/%0d/%0d want 4096/0/0", scale_step_o, scale_line_size_o, width_o); end
    checks++; if ({upd_o, pend_o, busy_o, err_o} !== 4'b0000) begin errors++; $display("FAIL rst_mid_flags got %b want 0000", {upd_o, pend_o, busy_o, err_o}); end
    rst  = 1'b0;
    vs_i = 1'b0;
    frame(24, 24);
    vblank(40, -1, 16'd0);
    checks++; if (scale_step_o !== 16'd4096 || scale_line_size_o !== 16'd24) begin errors++; $display("FAIL shadow_lost got %0d/%0d want 4096/24", scale_step_o, scale_line_size_o); end
    frame(24, 24);
    vblank(40, -1, 16'd0);
`ifdef SCALER_V_CTRL_STAT_EN
    checks++; if (stat_frames_o !== 16'd2) begin errors++; $display("FAIL stat_frames got %0d want 2", stat_frames_o); end
    checks++; if (stat_height_o !== 16'd24) begin errors++; $display("FAIL stat_height got %0d want 24", stat_height_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_write_2048();
    test_reject();
    test_abort();
    test_width_change();
    test_rst_mid_calc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
